// File: rtl/stream_buffer_fifo_ctrl_pkg.sv
// Shared definitions for the stream buffer FIFO controller: default sizes,
// output-buffer depth and the arbiter priority encoding.
package sbuf_pkg;

  localparam int SBUF_ADDR_W     = 11;
  localparam int SBUF_DATA_W     = 16;
  localparam int SBUF_OBUF_DEPTH = 2;

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } sbuf_prio_e;

endpackage

// File: rtl/stream_buffer_fifo_ctrl_out_buf2.sv
// Two-entry output buffer that absorbs BRAM read returns and presents the
// oldest word to the consumer. The head register always holds the oldest
// word; the tail register holds the second word when two are buffered.
module sbuf_out_buf2
  import sbuf_pkg::*;
#(
  parameter int DATA_W = SBUF_DATA_W,
  parameter int CNT_W  = $clog2(SBUF_OBUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid
);

  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_pop;

  assign do_pop     = pop && (count_q != '0);
  assign count      = count_q;
  assign head_data  = head_q;
  assign head_valid = (count_q != '0);

  // Shift-style storage: a pop promotes the tail into the head, a push lands
  // in the first free slot, and a simultaneous push/pop is honoured together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else begin
      case (count_q)
        CNT_W'(0): begin
          if (push) begin
            head_q  <= push_data;
            count_q <= CNT_W'(1);
          end
        end
        CNT_W'(1): begin
          if (push && do_pop) begin
            head_q <= push_data;
          end else if (push) begin
            tail_q  <= push_data;
            count_q <= CNT_W'(2);
          end else if (do_pop) begin
            count_q <= CNT_W'(0);
          end
        end
        default: begin
          if (do_pop) begin
            head_q <= tail_q;
            if (push) begin
              tail_q <= push_data;
            end else begin
              count_q <= CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/stream_buffer_fifo_ctrl.sv
// Valid/ready FIFO controller around the single-port stream buffer BRAM.
// Owns write/read pointers and BRAM occupancy, arbitrates the one BRAM port
// between producer writes and consumer-driven reads, and hides the 1-cycle
// read latency behind a 2-entry output buffer.
// Optional feature: define SBUF_FLUSH_EN to add the synchronous flush_in port.
module stream_buffer_fifo_ctrl
  import sbuf_pkg::*;
#(
  parameter int ADDR_W = SBUF_ADDR_W,
  parameter int DATA_W = SBUF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SBUF_FLUSH_EN
  input  logic              flush_in,
`endif
  input  logic [DATA_W-1:0] s_data_in,
  input  logic              s_valid_in,
  output logic              s_ready_out,
  output logic [DATA_W-1:0] m_data_out,
  output logic              m_valid_out,
  input  logic              m_ready_in,
  output logic [ADDR_W:0]   level_out,
  output logic [15:0]       bram_wr_addr_out,
  output logic [15:0]       bram_wr_data_out,
  output logic              bram_wr_en_out,
  output logic [15:0]       bram_rd_addr_out,
  output logic              bram_rd_en_out,
  input  logic [15:0]       bram_rd_data_in,
  input  logic              bram_rd_valid_in
);

  localparam int OBUF_CNT_W = $clog2(SBUF_OBUF_DEPTH + 1);

  sbuf_prio_e            state_q;
  sbuf_prio_e            state_next;
  logic [ADDR_W-1:0]     wp_q;
  logic [ADDR_W-1:0]     rp_q;
  logic [ADDR_W:0]       level_q;
  logic                  inflight_q;
  logic                  full;
  logic                  rd_want;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  flush;
  logic                  obuf_push;
  logic                  obuf_pop;
  logic [OBUF_CNT_W-1:0] obuf_count;

`ifdef SBUF_FLUSH_EN
  assign flush = flush_in;
`else
  assign flush = 1'b0;
`endif

  // Level never exceeds the depth, so its top bit alone marks a full BRAM.
  assign full    = level_q[ADDR_W];
  assign rd_want = (level_q != '0) &&
                   ((int'(obuf_count) + int'(inflight_q)) < SBUF_OBUF_DEPTH);

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRIO_WR;
    end else begin
      state_q <= state_next;
    end
  end

  // Priority flips to the other side after each fire so both sides share the port.
  always_comb begin
    state_next = state_q;
    if (flush) begin
      state_next = PRIO_WR;
    end else if (wr_fire) begin
      state_next = PRIO_RD;
    end else if (rd_fire) begin
      state_next = PRIO_WR;
    end
  end

  // Handshake and port-issue decisions; at most one BRAM operation per cycle.
  always_comb begin
    s_ready_out    = !flush && !full && (!rd_want || (state_q == PRIO_WR));
    wr_fire        = s_valid_in && s_ready_out;
    rd_fire        = !flush && rd_want && !wr_fire;
    bram_wr_en_out = wr_fire;
    bram_rd_en_out = rd_fire;
  end

  assign bram_wr_addr_out = 16'(wp_q);
  assign bram_rd_addr_out = 16'(rp_q);
  assign bram_wr_data_out = 16'(s_data_in);
  assign level_out        = level_q;

  // Pointers, occupancy and the single outstanding-read flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
      inflight_q <= 1'b0;
    end else if (flush) begin
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        wp_q <= wp_q + ADDR_W'(1);
      end
      if (rd_fire) begin
        rp_q <= rp_q + ADDR_W'(1);
      end
      if (wr_fire && !rd_fire) begin
        level_q <= level_q + (ADDR_W+1)'(1);
      end else if (rd_fire && !wr_fire) begin
        level_q <= level_q - (ADDR_W+1)'(1);
      end
      if (rd_fire) begin
        inflight_q <= 1'b1;
      end else if (bram_rd_valid_in) begin
        inflight_q <= 1'b0;
      end
    end
  end

  // Returns that no longer have an outstanding read (after reset or flush) are dropped.
  assign obuf_push = bram_rd_valid_in && inflight_q && !flush;
  assign obuf_pop  = m_valid_out && m_ready_in;

  sbuf_out_buf2 #(
    .DATA_W (DATA_W),
    .CNT_W  (OBUF_CNT_W)
  ) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (flush),
    .push       (obuf_push),
    .push_data  (DATA_W'(bram_rd_data_in)),
    .pop        (obuf_pop),
    .count      (obuf_count),
    .head_data  (m_data_out),
    .head_valid (m_valid_out)
  );

endmodule

// File: tb/tb_stream_buffer_fifo_ctrl.sv
// Scoreboard bench for stream_buffer_fifo_ctrl built with an 8-deep BRAM.
// Accepted producer words are queued as the expected output; a monitor pops
// and compares whenever the consumer takes a word.
module tb_stream_buffer_fifo_ctrl;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_data_in;
  logic          s_valid_in;
  logic          s_ready_out;
  logic [DW-1:0] m_data_out;
  logic          m_valid_out;
  logic          m_ready_in;
  logic [AW:0]   level_out;
  logic [15:0]   bram_wr_addr_out;
  logic [15:0]   bram_wr_data_out;
  logic          bram_wr_en_out;
  logic [15:0]   bram_rd_addr_out;
  logic          bram_rd_en_out;
  logic [15:0]   bram_rd_data_in;
  logic          bram_rd_valid_in;
`ifdef SBUF_FLUSH_EN
  logic          flush_in;
`endif

  int            n_checks;
  int            n_fail;
  int            cyc;
  int            n_pop;
  int            first_acc;
  int            first_val;
  logic [DW-1:0] exp_q[$];
  logic [15:0]   mem [0:(1<<AW)-1];

  stream_buffer_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
`ifdef SBUF_FLUSH_EN
    .flush_in         (flush_in),
`endif
    .s_data_in        (s_data_in),
    .s_valid_in       (s_valid_in),
    .s_ready_out      (s_ready_out),
    .m_data_out       (m_data_out),
    .m_valid_out      (m_valid_out),
    .m_ready_in       (m_ready_in),
    .level_out        (level_out),
    .bram_wr_addr_out (bram_wr_addr_out),
    .bram_wr_data_out (bram_wr_data_out),
    .bram_wr_en_out   (bram_wr_en_out),
    .bram_rd_addr_out (bram_rd_addr_out),
    .bram_rd_en_out   (bram_rd_en_out),
    .bram_rd_data_in  (bram_rd_data_in),
    .bram_rd_valid_in (bram_rd_valid_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: write on wr_en, registered read data and valid one cycle after rd_en.
  initial bram_rd_valid_in = 1'b0;
  always @(posedge clk) begin
    if (bram_wr_en_out) mem[bram_wr_addr_out[AW-1:0]] <= bram_wr_data_out;
    bram_rd_valid_in <= bram_rd_en_out;
    if (bram_rd_en_out) bram_rd_data_in <= mem[bram_rd_addr_out[AW-1:0]];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: record accepted words into the model queue and compare popped words.
  always @(negedge clk) begin
    logic [DW-1:0] exp_word;
    if (rst_n) begin
      checkOutput("single_bram_op", 32'(bram_wr_en_out && bram_rd_en_out), 32'd0);
      if (bram_wr_en_out) checkOutput("wr_addr_upper", 32'(bram_wr_addr_out[15:AW]), 32'd0);
      if (bram_rd_en_out) checkOutput("rd_addr_upper", 32'(bram_rd_addr_out[15:AW]), 32'd0);
      if (s_valid_in && s_ready_out) begin
        exp_q.push_back(s_data_in);
        if (first_acc < 0) first_acc = cyc;
      end
      if (m_valid_out && first_val < 0) first_val = cyc;
      if (m_valid_out && m_ready_in) begin
        n_pop++;
        checkOutput("model_nonempty_on_pop", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          checkOutput("data_order", 32'(m_data_out), 32'(exp_word));
        end
      end
    end
  end

  // Offer one word and hold it until the controller accepts it.
  task automatic applyStimulus(input logic [DW-1:0] data);
    s_valid_in = 1'b1;
    s_data_in  = data;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (s_ready_out) begin
        @(posedge clk); #2;
        s_valid_in = 1'b0;
        return;
      end
    end
    checkOutput("accept_timeout", 32'd0, 32'd1);
    s_valid_in = 1'b0;
  endtask

  // Let the consumer take everything and confirm the model empties.
  task automatic drain();
    s_valid_in = 1'b0;
    m_ready_in = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid_out && level_out == '0) break;
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    checkOutput("drain_model_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("drain_m_valid", 32'(m_valid_out), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int acc;
    int pops_before;
    int wr_prev;
    logic found;
    n_checks = 0; n_fail = 0; cyc = 0; n_pop = 0;
    first_acc = -1; first_val = -1;
    rst_n = 1'b0; s_valid_in = 1'b0; s_data_in = '0; m_ready_in = 1'b0;
`ifdef SBUF_FLUSH_EN
    flush_in = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_m_valid", 32'(m_valid_out), 32'd0);
    checkOutput("rst_level", 32'(level_out), 32'd0);
    checkOutput("rst_wr_en", 32'(bram_wr_en_out), 32'd0);
    checkOutput("rst_rd_en", 32'(bram_rd_en_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_s_ready", 32'(s_ready_out), 32'd1);
    @(posedge clk); #2;

    $display("[TB] five words with consumer ready");
    m_ready_in = 1'b1;
    for (int i = 1; i <= 5; i++) applyStimulus(DW'(i));
    drain();
    checkOutput("first_latency", 32'(first_val - first_acc), 32'd3);
    checkOutput("five_words_out", 32'(n_pop), 32'd5);

    $display("[TB] producer and consumer both continuous");
    m_ready_in = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) applyStimulus(DW'(16'h2000 + i));
      end
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        wr_prev     = int'(bram_wr_en_out);
        pops_before = n_pop;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          checkOutput("alt_one_op", 32'(bram_wr_en_out ^ bram_rd_en_out), 32'd1);
          checkOutput("alt_toggle", 32'(bram_wr_en_out), 32'(wr_prev == 0));
          wr_prev = int'(bram_wr_en_out);
        end
        checkOutput("alt_rate", 32'((n_pop - pops_before) >= 9 && (n_pop - pops_before) <= 11), 32'd1);
      end
    join
    drain();

    $display("[TB] fill with consumer stalled");
    do_reset();
    m_ready_in = 1'b0;
    s_valid_in = 1'b1;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      s_data_in = DW'(16'h0100 + acc);
      @(negedge clk);
      if (s_ready_out) acc++;
      @(posedge clk); #2;
    end
    checkOutput("fill_accepts", 32'(acc), 32'd10);
    @(negedge clk);
    checkOutput("fill_s_ready", 32'(s_ready_out), 32'd0);
    checkOutput("fill_level", 32'(level_out), 32'd8);
    @(posedge clk); #2;
    m_ready_in = 1'b1;
    @(posedge clk); #2;
    m_ready_in = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bram_rd_en_out) begin found = 1'b1; break; end
    end
    checkOutput("full_read_issue_seen", 32'(found), 32'd1);
    @(negedge clk);
    checkOutput("full_ready_back", 32'(s_ready_out), 32'd1);
    @(posedge clk); #2;
    s_valid_in = 1'b0;
    drain();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      s_valid_in = ($urandom_range(0, 3) != 0);
      s_data_in  = DW'($urandom);
      m_ready_in = ($urandom_range(0, 2) != 0);
      @(posedge clk); #2;
    end
    drain();

    $display("[TB] reset with a read in flight");
    m_ready_in = 1'b0;
    applyStimulus(16'h0A0A);
    found = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bram_rd_en_out) begin found = 1'b1; break; end
    end
    checkOutput("inflight_read_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    m_ready_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("late_ret_m_valid", 32'(m_valid_out), 32'd0);
      checkOutput("late_ret_level", 32'(level_out), 32'd0);
    end
    @(posedge clk); #2;
    applyStimulus(16'h5A5A);
    drain();

`ifdef SBUF_FLUSH_EN
    $display("[TB] flush with words held");
    m_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(DW'(16'h0300 + i));
    repeat (6) @(posedge clk);
    #2;
    flush_in = 1'b1;
    exp_q.delete();
    @(posedge clk); #2;
    flush_in = 1'b0;
    @(negedge clk);
    checkOutput("flush_level", 32'(level_out), 32'd0);
    checkOutput("flush_m_valid", 32'(m_valid_out), 32'd0);
    checkOutput("flush_s_ready", 32'(s_ready_out), 32'd1);
    @(posedge clk); #2;
    m_ready_in = 1'b1;
    applyStimulus(16'hBEEF);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
